// File: rtl/md_pkg.sv
// md_pkg: opcode/funct constants, FSM states and watchdog limit shared by the MDU issue controller.
package md_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] F_MULT     = 6'b011000;
  localparam logic [5:0] F_MULTU    = 6'b011001;
  localparam logic [5:0] F_DIV      = 6'b011010;
  localparam logic [5:0] F_DIVU     = 6'b011011;
  localparam logic [5:0] F_MTHI     = 6'b010001;
  localparam logic [5:0] F_MTLO     = 6'b010011;
  localparam logic [5:0] F_MFHI     = 6'b010000;
  localparam logic [5:0] F_MFLO     = 6'b010010;
  localparam logic [3:0] WD_LIMIT   = 4'd15;
  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, MOVE, READ} state_t;
endpackage

// File: rtl/md_op_decode.sv
// md_op_decode: classifies a decode-stage word as MD (mul/div), MT (move-to) or MF (move-from) HI/LO op.
module md_op_decode
  import md_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_md,
  output logic        is_mt,
  output logic        is_mf
);
  logic       sp;
  logic [5:0] f;
  assign sp    = instr[31:26] == OP_SPECIAL;
  assign f     = instr[5:0];
  assign is_md = sp & (f == F_MULT | f == F_MULTU | f == F_DIV | f == F_DIVU);
  assign is_mt = sp & (f == F_MTHI | f == F_MTLO);
  assign is_mf = sp & (f == F_MFHI | f == F_MFLO);
endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issues HI/LO ops from decode to the MDU, stalls decode while busy, returns MF results.
// Optional busy watchdog with sticky md_err: define MD_ISSUE_WATCHDOG_EN.
module md_issue_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] d_rt_val,
  output logic        d_stall,
  output logic [31:0] md_instr,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_start,
  input  logic        md_busy,
  input  logic [31:0] md_hilo,
  output logic        e_mf_valid,
  output logic [31:0] e_mf_data,
  output logic [4:0]  e_mf_rd,
  output logic        md_err
);
  state_t      state, state_n, tgt;
  logic        is_md, is_mt, is_mf, hilo, accept, wd_hit;
  logic [31:0] instr_q, rs_q, rt_q;
  logic [4:0]  rd_q;
  md_op_decode u_dec (.instr(d_instr), .is_md(is_md), .is_mt(is_mt), .is_mf(is_mf));
  assign hilo     = is_md | is_mt | is_mf;
  assign d_stall  = d_valid & hilo & ((state inside {ISSUE, MOVE, READ}) | (state == BUSY & md_busy));
  // Outside IDLE and a finished BUSY the stall term blocks any HI/LO op, so this is the only accept qualifier.
  assign accept   = d_valid & hilo & ~d_stall;
  assign md_start = state == ISSUE;
  assign md_instr = (state inside {ISSUE, MOVE, READ}) ? instr_q : '0;
  assign md_a     = (state inside {ISSUE, MOVE}) ? rs_q : '0;
  assign md_b     = (state == ISSUE) ? rt_q : '0;
  always_comb begin
    tgt     = is_md ? ISSUE : is_mt ? MOVE : READ;
    state_n = (state == ISSUE) ? BUSY :
              (state == BUSY & md_busy & ~wd_hit) ? BUSY :
              accept ? tgt : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      instr_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      e_mf_valid <= 1'b0;
      e_mf_data  <= '0;
      e_mf_rd    <= '0;
    end else begin
      state      <= state_n;
      e_mf_valid <= state == READ;
      if (accept) begin
        instr_q <= d_instr;
        rs_q    <= d_rs_val;
        rt_q    <= d_rt_val;
        rd_q    <= d_instr[15:11];
      end
      if (state == READ) begin
        e_mf_data <= md_hilo;
        e_mf_rd   <= rd_q;
      end
    end
  end
`ifdef MD_ISSUE_WATCHDOG_EN
  logic [3:0] wd_cnt;
  logic       err_q;
  // wd_hit marks the 15th consecutive busy cycle; the FSM bails to IDLE at its edge.
  assign wd_hit = state == BUSY & md_busy & wd_cnt == WD_LIMIT - 4'd1;
  assign md_err = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == BUSY & md_busy & ~wd_hit) ? wd_cnt + 4'd1 : '0;
      err_q  <= err_q | wd_hit;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign md_err = 1'b0;
`endif
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed vectors against md_issue_ctrl with a behavioural MDU (5-cycle mult, 10-cycle div).
module tb_md_issue_ctrl;
  logic        clk = 0, reset = 1, d_valid = 0, d_stall, md_start, md_busy, e_mf_valid, md_err;
  logic [31:0] d_instr = 0, d_rs_val = 0, d_rt_val = 0, md_instr, md_a, md_b, md_hilo, e_mf_data;
  logic [4:0]  e_mf_rd;
  int vecs = 0, errs = 0, n_start = 0, n_mf = 0;
  logic [31:0] hi, lo, ph, pl, rh, rl;
  logic [3:0]  bcnt;
  logic        stuck = 0;

  md_issue_ctrl dut (.clk(clk), .reset(reset), .d_valid(d_valid), .d_instr(d_instr), .d_rs_val(d_rs_val),
    .d_rt_val(d_rt_val), .d_stall(d_stall), .md_instr(md_instr), .md_a(md_a), .md_b(md_b),
    .md_start(md_start), .md_busy(md_busy), .md_hilo(md_hilo), .e_mf_valid(e_mf_valid),
    .e_mf_data(e_mf_data), .e_mf_rd(e_mf_rd), .md_err(md_err));

  always #5 clk = ~clk;

  // MDU model
  assign md_busy = bcnt != 0 || stuck;
  assign md_hilo = md_instr[31:26] != 0 ? 32'h0 : md_instr[5:0] == 6'b010000 ? hi :
                   md_instr[5:0] == 6'b010010 ? lo : 32'h0;
  always_comb begin
    logic signed [63:0] sp;
    logic [63:0] up;
    sp = $signed(md_a) * $signed(md_b);
    up = {32'h0, md_a} * {32'h0, md_b};
    rh = 0; rl = 0;
    case (md_instr[5:0])
      6'b011000: {rh, rl} = sp;
      6'b011001: {rh, rl} = up;
      6'b011010: if (md_b != 0) begin rl = $signed(md_a) / $signed(md_b); rh = $signed(md_a) % $signed(md_b); end
      6'b011011: if (md_b != 0) begin rl = md_a / md_b; rh = md_a % md_b; end
      default: ;
    endcase
  end
  always @(posedge clk) begin
    if (reset) begin
      bcnt <= 0; hi <= 0; lo <= 0; ph <= 0; pl <= 0;
    end else begin
      if (md_start) begin
        bcnt <= md_instr[1] ? 4'd10 : 4'd5;
        ph <= rh; pl <= rl;
      end else if (bcnt != 0) begin
        bcnt <= bcnt - 1;
        if (bcnt == 1) begin hi <= ph; lo <= pl; end
      end
      if (md_instr[31:26] == 0 && md_instr[5:0] == 6'b010001) hi <= md_a;
      if (md_instr[31:26] == 0 && md_instr[5:0] == 6'b010011) lo <= md_a;
    end
  end

  always @(negedge clk) if (!reset) begin
    if (md_start) n_start++;
    if (e_mf_valid) n_mf++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rop(input logic [5:0] f, input logic [4:0] rd);
    return {6'b0, 5'd1, 5'd2, rd, 5'b0, f};
  endfunction

  // Present an op, wait (bounded) for it to be accepted, then drop d_valid; returns cycles stalled.
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, output int stalls);
    d_valid = 1; d_instr = ins; d_rs_val = rs; d_rt_val = rt; stalls = 0;
    #1;
    while (d_stall && stalls < 40) begin tick; stalls++; end
    if (stalls >= 40) chk("accept_timeout", 32'(stalls), 32'd0);
    tick;
    d_valid = 0; d_instr = 0;
  endtask

  initial begin
    int s, b_start, b_mf, n;
    logic seen_stall, seen_instr;
    repeat (3) tick;
    chk("rst_start", {31'b0, md_start}, 0);
    chk("rst_instr", md_instr, 0);
    chk("rst_mfv", {31'b0, e_mf_valid}, 0);
    chk("rst_err", {31'b0, md_err}, 0);
    reset = 0;
    tick;

    // 1: MULT -2*3 then MFLO
    b_start = n_start; b_mf = n_mf;
    send(rop(6'b011000, 5'd0), 32'hFFFFFFFE, 32'd3, s);
    chk("t1_start", {31'b0, md_start}, 1);
    chk("t1_a", md_a, 32'hFFFFFFFE);
    chk("t1_b", md_b, 32'd3);
    send(rop(6'b010010, 5'd5), 0, 0, s);
    chk("t1_stalls", 32'(s), 32'd6);
    chk("t1_read_instr", md_instr, rop(6'b010010, 5'd5));
    tick;
    chk("t1_mfv", {31'b0, e_mf_valid}, 1);
    chk("t1_data", e_mf_data, 32'hFFFFFFFA);
    chk("t1_rd", {27'b0, e_mf_rd}, 32'd5);
    repeat (3) tick;
    chk("t1_nstart", 32'(n_start - b_start), 32'd1);
    chk("t1_nmf", 32'(n_mf - b_mf), 32'd1);

    // 2: DIVU 100/7 then MFHI
    send(rop(6'b011011, 5'd0), 32'd100, 32'd7, s);
    send(rop(6'b010000, 5'd7), 0, 0, s);
    chk("t2_stalls", 32'(s), 32'd11);
    tick;
    chk("t2_mfv", {31'b0, e_mf_valid}, 1);
    chk("t2_data", e_mf_data, 32'd2);
    chk("t2_rd", {27'b0, e_mf_rd}, 32'd7);
    tick;

    // 3: MTHI then MFHI back-to-back
    send(rop(6'b010001, 5'd0), 32'h12345678, 0, s);
    chk("t3_move_instr", md_instr, rop(6'b010001, 5'd0));
    chk("t3_move_a", md_a, 32'h12345678);
    send(rop(6'b010000, 5'd9), 0, 0, s);
    chk("t3_stalls", 32'(s), 32'd1);
    tick;
    chk("t3_data", e_mf_data, 32'h12345678);
    tick;

    // 4: ADDU in decode while the MDU is busy
    b_start = n_start; b_mf = n_mf;
    send(rop(6'b011000, 5'd0), 32'd2, 32'd3, s);
    tick;
    d_valid = 1; d_instr = 32'h00221821;
    seen_stall = 0; seen_instr = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      seen_stall |= d_stall;
      seen_instr |= md_instr != 0;
      tick;
    end
    d_valid = 0; d_instr = 0;
    chk("t4_stall", {31'b0, seen_stall}, 0);
    chk("t4_instr", {31'b0, seen_instr}, 0);
    chk("t4_nstart", 32'(n_start - b_start), 32'd1);
    chk("t4_nmf", 32'(n_mf - b_mf), 32'd0);

    // 5: reset in 3rd busy cycle of DIV
    send(rop(6'b011010, 5'd0), 32'hFFFFFFEC, 32'd3, s);
    repeat (3) tick;
    chk("t5_busy", {31'b0, md_busy}, 1);
    reset = 1; d_valid = 1; d_instr = rop(6'b010010, 5'd3);
    tick;
    chk("t5_stall", {31'b0, d_stall}, 0);
    chk("t5_start", {31'b0, md_start}, 0);
    chk("t5_mfv", {31'b0, e_mf_valid}, 0);
    chk("t5_instr", md_instr, 0);
    reset = 0; d_valid = 0; d_instr = 0;
    tick;

    // 6: watchdog
`ifdef MD_ISSUE_WATCHDOG_EN
    stuck = 1;
    send(rop(6'b011000, 5'd0), 32'd1, 32'd1, s);
    n = 0;
    while (!md_err && n < 40) begin tick; n++; end
    chk("t6_err_cycles", 32'(n), 32'd16);
    d_valid = 1; d_instr = rop(6'b010010, 5'd1);
    #1;
    chk("t6_stall", {31'b0, d_stall}, 0);
    d_valid = 0; d_instr = 0;
    repeat (3) tick;
    chk("t6_sticky", {31'b0, md_err}, 1);
    reset = 1; stuck = 0;
    tick;
    reset = 0;
    chk("t6_err_clr", {31'b0, md_err}, 0);
`else
    n = 0;
    chk("t6_err_off", {31'b0, md_err}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Pipeline-side initiator for the multiply/divide unit (MDU). It sits between the decode stage and the MDU. It accepts HI/LO-class instructions (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO) from decode and issues each one to the MDU under the MDU's start/busy protocol. While the MDU is occupied it stalls decode and returns MFHI/MFLO results to the writeback path.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- d_valid  in  1  decode-stage instruction valid
- d_instr  in  32  decode-stage instruction word
- d_rs_val  in  32  rs operand value
- d_rt_val  in  32  rt operand value
- d_stall  out  1  hold decode; combinational
- md_instr  out  32  instruction presented to MDU; 32'h0 when not driving an op
- md_a  out  32  MDU operand A
- md_b  out  32  MDU operand B
- md_start  out  1  MDU start
- md_busy  in  1  MDU busy
- md_hilo  in  32  MDU HI/LO read data, combinational from md_instr
- e_mf_valid  out  1  one-cycle pulse: MF result ready
- e_mf_data  out  32  MF result
- e_mf_rd  out  5  MF destination register
- md_err  out  1  sticky watchdog error

## Operation
- **Op classes**, decoded when op==6'b000000:
  - MD: funct 011000 (MULT), 011001 (MULTU), 011010 (DIV), 011011 (DIVU)
  - MT: funct 010001 (MTHI), 010011 (MTLO)
  - MF: funct 010000 (MFHI), 010010 (MFLO)
  - Any other instruction is ignored and never stalled.
- **Accept**: a HI/LO op is accepted on an edge where d_valid & !d_stall. On accept, the block registers the instr, rs_val, rt_val and rd (instr[15:11]).
- **States**: IDLE, ISSUE, BUSY, MOVE, READ.
  - IDLE -> ISSUE / MOVE / READ on accepting an MD / MT / MF op.
  - ISSUE: md_start=1 and md_instr/md_a/md_b driven. Goes to BUSY unconditionally next cycle.
  - BUSY: md_instr=0, md_start=0. Waits for md_busy==0. In that cycle the block may accept a new op and go directly to its state; otherwise it goes to IDLE. If the MDU never raised busy, BUSY exits after one cycle.
  - MOVE: md_instr=MT op and md_a=rs_val for one cycle (the MDU writes HI/LO at the edge), then IDLE.
  - READ: md_instr=MF op for one cycle. md_hilo is captured into e_mf_data, with e_mf_rd, and e_mf_valid pulses the following cycle. Then IDLE.
- **d_stall** = d_valid & HI/LO op & (state in {ISSUE, MOVE, READ} | (state==BUSY & md_busy)).
- Operands pass through unmodified, including divide by zero; the result is the MDU's concern.
- **Reset**: all outputs 0 and state IDLE, also when reset arrives mid-operation. The MDU shares the reset.

## Timing
- MD op accepted at the end of cycle T:
  - ISSUE in T+1.
  - MDU busy in T+2..T+6 for mult, T+2..T+11 for div.
  - HI/LO written at the last busy edge.
  - d_stall for HI/LO ops releases in T+7 (mult) or T+12 (div).
- MT: HI/LO updated at the end of T+1; the earliest following HI/LO op is accepted in T+1's successor.
- MF accepted at T: READ in T+1, e_mf_valid=1 in T+2.
- Maximum throughput is one HI/LO op per 2 cycles.

## Configuration
- **MD_ISSUE_WATCHDOG_EN** defined:
  - A 4-bit counter counts cycles in BUSY with md_busy=1.
  - When it reaches 15, md_err sets (sticky until reset) and the state forces to IDLE.
- Undefined: no counter; md_err is tied 0.

## Structure
- **Shared package md_pkg**: opcode/funct constants for the eight ops; state enum; watchdog limit constant (15).
- **Sub-module md_op_decode**: combinational; d_instr -> is_md, is_mt, is_mf.
- The FSM, operand registers and MF capture stay in md_issue_ctrl.

## Test plan
1. MULT, rs=32'hFFFFFFFE, rt=3, with MFLO in decode the next cycle:
   - md_start=1 only in T+1.
   - d_stall high until busy falls.
   - e_mf_data=32'hFFFFFFFA and e_mf_valid exactly once.
2. DIVU 100/7 followed immediately by MFHI:
   - stall covers the 10 busy cycles.
   - e_mf_data=2 delivered 2 cycles after accept.
3. MTHI rs=32'h12345678, then MFHI back-to-back:
   - MFHI stalled one cycle.
   - e_mf_data=32'h12345678.
4. ADDU in decode while BUSY -> d_stall=0 throughout; no MDU activity.
5. Reset asserted in the 3rd busy cycle of DIV -> next cycle: state IDLE, d_stall=0, md_start=0, e_mf_valid=0.
6. With MD_ISSUE_WATCHDOG_EN, md_busy held at 1 -> md_err=1 after 15 busy cycles, stall released, md_err stays 1 until reset.
